// File: rtl/rca_seq_ctrl.sv
// Two-requester adder controller that time-shares a single 3-bit
// ripple-carry slice across all chunks of a W = 3*NCHUNK bit operand.

module rca (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] sum,
    output logic       cout
);
    logic [3:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 3; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[3];
endmodule

module rca_seq_ctrl #(
    parameter int NCHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [3*NCHUNK-1:0] req0_a,
    input  logic [3*NCHUNK-1:0] req0_b,
    input  logic [3*NCHUNK-1:0] req1_a,
    input  logic [3*NCHUNK-1:0] req1_b,
    input  logic                req0_cin,
    input  logic                req1_cin,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [3*NCHUNK-1:0] res_sum,
    output logic                res_cout,
    output logic                res_id,
    output logic                busy
);
    localparam int W  = 3 * NCHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic [KW-1:0] k;
    logic          carry, cout_q, id_q, last;
    logic          any_valid, gnt, accept, last_chunk;
    logic [2:0]    slice_a, slice_b, slice_s;
    logic          slice_co;

    assign any_valid  = req0_valid | req1_valid;
    // Contention goes to whoever was not served last; last resets to 1
    assign gnt        = req0_valid ? (req1_valid & ~last) : 1'b1;
    assign accept     = (state == IDLE) & rst_n & any_valid;
    assign last_chunk = (k == KW'(NCHUNK - 1));

    assign slice_a = a_q[k*3 +: 3];
    assign slice_b = b_q[k*3 +: 3];

    rca u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_s),
        .cout (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = ADD;
            ADD:  if (last_chunk) state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        res_valid  = (state == DONE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            k      <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            id_q   <= 1'b0;
            last   <= 1'b1;
        end else begin
            if (accept) begin
                a_q   <= gnt ? req1_a : req0_a;
                b_q   <= gnt ? req1_b : req0_b;
                carry <= gnt ? req1_cin : req0_cin;
                sum_q <= '0;
                k     <= '0;
                id_q  <= gnt;
                last  <= gnt;
            end else if (state == ADD) begin
                sum_q[k*3 +: 3] <= slice_s;
                carry           <= slice_co;
                k               <= k + 1'b1;
                if (last_chunk) cout_q <= slice_co;
            end
        end
    end

    assign res_sum  = sum_q;
    assign res_cout = cout_q;
    assign res_id   = id_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl: latency, carry ripple, round-robin,
// back-pressure, reset abort and operand isolation.

module tb_rca_seq_ctrl;
    localparam int NCHUNK = 4;
    localparam int W      = 3 * NCHUNK;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id, busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    rca_seq_ctrl #(.NCHUNK(NCHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_cin   (req0_cin),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the acceptance edge until res_valid is seen
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!res_valid && n < 20);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rv"}, res_valid, 0);
        check({tag, "_sum"}, res_sum, 0);
        check({tag, "_cout"}, res_cout, 0);
        check({tag, "_id"}, res_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, {req0_ready, req1_ready}, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready  = 1'b0;
        #12;
        check_reset_outs("rst");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #5 rst_n = 1'b1;
        step();

        // req0 0x123 + 0x456, operand changed mid-operation
        req0_valid = 1'b1;
        req0_a = 12'h123; req0_b = 12'h456; req0_cin = 1'b0;
        #1;
        check("t1_rdy", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req0_a = 12'hFFF;
        req0_b = 12'h001;
        check("t1_busy", busy, 1);
        check("t1_rdy_add", {req0_ready, req1_ready}, 0);
        wait_done(cyc);
        check("t1_lat", cyc, NCHUNK);
        check("t1_sum", res_sum, 12'h579);
        check("t1_cout", res_cout, 0);
        check("t1_id", res_id, 0);

        // Back-pressure with a pending request
        req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_rv", res_valid, 1);
            check("bp_sum", res_sum, 12'h579);
            check("bp_cout", res_cout, 0);
            check("bp_rdy", {req0_ready, req1_ready}, 0);
            check("bp_busy", busy, 1);
        end
        req0_valid = 1'b0;
        res_ready  = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_rv_low", res_valid, 0);
        check("bp_idle", busy, 0);

        // req1 0xFFF + 0x000 + 1: carry through every chunk
        req1_valid = 1'b1;
        req1_a = 12'hFFF; req1_b = 12'h000; req1_cin = 1'b1;
        #1;
        check("t2_rdy", {req0_ready, req1_ready}, 2'b01);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_done(cyc);
        check("t2_lat", cyc, NCHUNK);
        check("t2_sum", res_sum, 12'h000);
        check("t2_cout", res_cout, 1);
        check("t2_id", res_id, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t2_rv_low", res_valid, 0);

        // Reset pulse during the second ADD cycle
        req1_valid = 1'b1;
        req1_a = 12'h777; req1_b = 12'h111; req1_cin = 1'b0;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("abort");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_norv", res_valid, 0);
        end

        // Round-robin under contention, pointer freshly reset
        req0_a = 12'h0AB; req0_b = 12'h154; req0_cin = 1'b1;
        req1_a = 12'h800; req1_b = 12'h900; req1_cin = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        #1;
        check("rr1_rdy", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        wait_done(cyc);
        check("rr1_lat", cyc, NCHUNK);
        check("rr1_id", res_id, 0);
        check("rr1_sum", res_sum, 12'h200);
        check("rr1_cout", res_cout, 0);
        step();
        check("rr2_rdy", {req0_ready, req1_ready}, 2'b01);
        @(posedge clk);
        #1;
        wait_done(cyc);
        check("rr2_lat", cyc, NCHUNK);
        check("rr2_id", res_id, 1);
        check("rr2_sum", res_sum, 12'h100);
        check("rr2_cout", res_cout, 1);
        step();
        check("rr3_rdy", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done(cyc);
        check("rr3_id", res_id, 0);
        check("rr3_sum", res_sum, 12'h200);
        step();
        check("end_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NCHUNK, default 4: number of 3-bit chunks per operand; operand width W = 3*NCHUNK (12 at default).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each: requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted on valid&ready at a clk edge.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W each: operands.
REQ-007 The block SHALL have ports req0_cin/req1_cin, input, 1 each: carry-in.
REQ-008 The block SHALL have port res_valid, output, 1: result available.
REQ-009 The block SHALL have port res_ready, input, 1: consumer takes result on res_valid&res_ready.
REQ-010 The block SHALL have ports res_sum (output, W: sum), res_cout (output, 1: carry out of bit W-1), res_id (output, 1: index of the requester served).
REQ-011 The block SHALL have port busy, output, 1: high in ADD or DONE.

Function
REQ-012 The block SHALL instantiate exactly one 3-bit ripple-carry adder slice (team module rca) and time-share it across all chunks and both requesters; no other adder logic is permitted.
REQ-013 The FSM SHALL have three states: IDLE, ADD, DONE.
REQ-014 In IDLE, exactly one of req0_ready/req1_ready SHALL be high when any valid is high: the granted requester; with no valid high, both readys are low.
REQ-015 Grant SHALL be round-robin: one valid wins outright; both valid goes to the requester not served last.
REQ-016 readys SHALL be low in ADD and DONE, and low while rst_n is low.
REQ-017 On acceptance, operands, cin and grant index SHALL be registered; the chunk counter SHALL be cleared to 0; the FSM SHALL move to ADD.
REQ-018 In ADD, each cycle SHALL feed chunk k (bits 3k+2..3k) of a and b plus the running carry to the slice, store the 3 sum bits into result bits 3k+2..3k, store the slice cout as the running carry, and increment k.
REQ-019 The running carry for chunk 0 SHALL be the registered cin.
REQ-020 After the chunk NCHUNK-1 edge, the FSM SHALL enter DONE with res_valid=1 and res_cout equal to the final carry; res_valid rises exactly NCHUNK cycles after the acceptance edge (4 at default).
REQ-021 In DONE, res_sum, res_cout and res_id SHALL be held stable until res_valid&res_ready; on that edge res_valid falls and the FSM returns to IDLE.
REQ-022 A new acceptance SHALL occur no earlier than the cycle after the result handshake; throughput is one operation per NCHUNK+2 cycles minimum.
REQ-023 Requester inputs SHALL be ignored outside the acceptance edge; operand changes during ADD SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be unsigned modulo 2^W with cout as overflow; {res_cout,res_sum} = a + b + cin.
REQ-025 The round-robin pointer SHALL update only on acceptance.

Reset
REQ-026 On rst_n low, the block SHALL immediately force: FSM=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, counter=0, running carry=0, readys=0.
REQ-027 On rst_n low, the round-robin pointer SHALL reset so req0 wins the first contention.
REQ-028 Reset asserted during ADD or DONE SHALL discard the in-flight operation with no result produced; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-029 The bench SHALL drive req0 a=0x123, b=0x456, cin=0 -> res_sum=0x579, res_cout=0, res_id=0, res_valid 4 cycles after acceptance.
REQ-030 The bench SHALL drive req1 a=0xFFF, b=0x000, cin=1 -> res_sum=0x000, res_cout=1, res_id=1; the carry rippling through all 4 chunks SHALL be checked.
REQ-031 The bench SHALL raise req0_valid and req1_valid together after reset, hold res_ready=1 -> req0 is served first, req1 next, then req0 again if both remain valid.
REQ-032 The bench SHALL hold res_ready=0 for 10 cycles in DONE -> res_* stable, both readys low, busy=1; the handshake then returns the FSM to IDLE.
REQ-033 The bench SHALL pulse rst_n low in the 2nd ADD cycle -> all outputs reach their reset values without a clock edge; no res_valid for the aborted operation; the next request completes correctly.
REQ-034 The bench SHALL change req0_a during ADD -> the result reflects only the operands captured at acceptance.
